// File: rtl/hilas_scan_pkg.sv
// rtl/hilas_scan_pkg.sv - shared types and default parameters for the HILAS scan-chain sequencer
//
// Contents:
//   scan_state_t    - sequencer state encoding
//   SCAN_WIDTH_DEF  - default scan chain length in bits
//   SCAN_DIV_DEF    - default scan clock half-period in system clock cycles
//   SCAN_RST_DEF    - default chain reset pulse length in system clock cycles

package hilas_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR      = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } scan_state_t;

    localparam int SCAN_WIDTH_DEF = 16;
    localparam int SCAN_DIV_DEF   = 4;
    localparam int SCAN_RST_DEF   = 8;

endpackage

// File: rtl/hilas_scan_phase_cnt.sv
// rtl/hilas_scan_phase_cnt.sv - loadable down-counter with terminal-count flag for scan phase timing
//
// Ports:
//   clk_i       - system clock
//   rst_ni      - asynchronous active-low reset
//   load_i      - load load_val_i into the counter (overrides counting)
//   load_val_i  - reload value, i.e. phase length minus one
//   tc_o        - high while the count is zero (last cycle of the phase)

module hilas_scan_phase_cnt #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates at zero so an idle counter simply parks with tc_o high.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/hilas_scan_ctrl.sv
// rtl/hilas_scan_ctrl.sv - serial loader / readback sequencer for the sky130_hilas_ScannerVertical chain
//
// Optional feature macro: HILAS_SCAN_READBACK_EN (capture register and rd_data readback).
//
// Ports:
//   CLK          - system clock
//   RESET_B      - asynchronous active-low reset
//   start_valid  - host offers a job
//   start_ready  - sequencer idle and able to accept a job
//   start_data   - word to shift into the chain, MSB first
//   start_clr    - pulse the chain reset before shifting
//   scan_d       - scanner D
//   scan_clk     - scanner CLK1
//   scan_rst_b   - scanner RESET_B_1
//   scan_q       - scanner OUTPUT
//   busy         - job in progress
//   done         - one-cycle completion pulse
//   rd_data      - previous chain contents captured during the last job

module hilas_scan_ctrl
    import hilas_scan_pkg::*;
#(
    parameter int WIDTH      = SCAN_WIDTH_DEF,
    parameter int DIV        = SCAN_DIV_DEF,
    parameter int RST_CYCLES = SCAN_RST_DEF
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_data,
    input  logic             start_clr,
    output logic             scan_d,
    output logic             scan_clk,
    output logic             scan_rst_b,
    input  logic             scan_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data
);

    // One counter serves both the CLR pulse and the scan half-periods, so it
    // is sized for whichever phase is longer.
    localparam int MAXV = (DIV > RST_CYCLES) ? DIV : RST_CYCLES;
    localparam int CW   = $clog2(MAXV + 1);
    localparam int BW   = $clog2(WIDTH);

    localparam logic [CW-1:0] DIV_LD  = CW'(DIV - 1);
    localparam logic [CW-1:0] RST_LD  = CW'(RST_CYCLES - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);

    scan_state_t      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [BW-1:0]    bit_q, bit_d;

    logic ready_q, busy_q, done_q;
    logic scan_d_q, scan_d_d;
    logic scan_clk_q, scan_rst_b_q;

    logic          accept;
    logic          phase_tc;
    logic          phase_load;
    logic [CW-1:0] phase_val;
    logic          lo_end;
    logic          hi_end;

    assign accept = start_valid && ready_q;
    assign lo_end = (state_q == ST_SHIFT_LO) && phase_tc;
    assign hi_end = (state_q == ST_SHIFT_HI) && phase_tc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = start_clr ? ST_CLR : ST_SHIFT_LO;
                end
            end
            ST_CLR: begin
                if (phase_tc) begin
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_tc) begin
                    state_d = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_tc) begin
                    state_d = (bit_q == '0) ? ST_DONE : ST_SHIFT_LO;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Word is consumed from the MSB; the shift happens as each bit's high
    // phase ends, so the next bit is at sr_d[WIDTH-1] on SHIFT_LO entry.
    always_comb begin
        sr_d  = sr_q;
        bit_d = bit_q;
        if (accept) begin
            sr_d  = start_data;
            bit_d = BIT_TOP;
        end else if (hi_end && (bit_q != '0)) begin
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            bit_d = bit_q - 1'b1;
        end
    end

    // scan_d is only updated on entry to SHIFT_LO and held through SHIFT_HI,
    // giving DIV cycles of setup and hold around the rising scan_clk edge.
    always_comb begin
        case (state_d)
            ST_SHIFT_LO: scan_d_d = sr_d[WIDTH-1];
            ST_SHIFT_HI: scan_d_d = scan_d_q;
            default:     scan_d_d = 1'b0;
        endcase
    end

    assign phase_load = (state_d != state_q);
    assign phase_val  = (state_d == ST_CLR) ? RST_LD : DIV_LD;

    hilas_scan_phase_cnt #(
        .CW(CW)
    ) u_phase_cnt (
        .clk_i      (CLK),
        .rst_ni     (RESET_B),
        .load_i     (phase_load),
        .load_val_i (phase_val),
        .tc_o       (phase_tc)
    );

    // Every output register is loaded from the next state so pin behaviour
    // lines up with the state the sequencer is in during that cycle.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            bit_q        <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            scan_d_q     <= 1'b0;
            scan_clk_q   <= 1'b0;
            scan_rst_b_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_q        <= bit_d;
            ready_q      <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            scan_d_q     <= scan_d_d;
            scan_clk_q   <= (state_d == ST_SHIFT_HI);
            scan_rst_b_q <= (state_d != ST_CLR);
        end
    end

    assign start_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign scan_d      = scan_d_q;
    assign scan_clk    = scan_clk_q;
    assign scan_rst_b  = scan_rst_b_q;

`ifdef HILAS_SCAN_READBACK_EN
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rd_q;

    // scan_q is sampled on the last SHIFT_LO cycle, just before scan_clk
    // rises, so the first sample is the chain's last stage and lands in the
    // MSB once all WIDTH samples have been shifted in.
    always_comb begin
        cap_d = cap_q;
        if (accept) begin
            cap_d = '0;
        end else if (lo_end) begin
            cap_d = {cap_q[WIDTH-2:0], scan_q};
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            cap_q <= '0;
            rd_q  <= '0;
        end else begin
            cap_q <= cap_d;
            if (state_d == ST_DONE) begin
                rd_q <= cap_d;
            end
        end
    end

    assign rd_data = rd_q;
`else
    logic unused_scan_q;
    assign unused_scan_q = scan_q;
    assign rd_data       = '0;
`endif

endmodule

// File: tb/tb_hilas_scan_ctrl.sv
// tb/tb_hilas_scan_ctrl.sv - self-checking bench for hilas_scan_ctrl with a behavioural scan chain model

module tb_hilas_scan_ctrl;

    localparam int W = 8;
    localparam int D = 2;
    localparam int R = 3;

    logic         CLK = 1'b0;
    logic         RESET_B;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] start_data;
    logic         start_clr;
    logic         scan_d;
    logic         scan_clk;
    logic         scan_rst_b;
    logic         scan_q;
    logic         busy;
    logic         done;
    logic [W-1:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] chain;
    logic [W-1:0] preload_val;
    logic         preload_stb = 1'b0;
    logic [W-1:0] exp_chain;
    logic [W-1:0] exp_prev_rd;

    always #5 CLK = ~CLK;

    hilas_scan_ctrl #(
        .WIDTH      (W),
        .DIV        (D),
        .RST_CYCLES (R)
    ) dut (
        .CLK         (CLK),
        .RESET_B     (RESET_B),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_data  (start_data),
        .start_clr   (start_clr),
        .scan_d      (scan_d),
        .scan_clk    (scan_clk),
        .scan_rst_b  (scan_rst_b),
        .scan_q      (scan_q),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data)
    );

    // Scanner island: W-stage shift register, D enters stage 0, OUTPUT is the last stage.
    always @(posedge scan_clk or negedge scan_rst_b or posedge preload_stb) begin
        if (preload_stb) begin
            chain <= preload_val;
        end else if (!scan_rst_b) begin
            chain <= '0;
        end else begin
            chain <= {chain[W-2:0], scan_d};
        end
    end
    assign scan_q = chain[W-1];

    function automatic logic [W-1:0] rb(input logic [W-1:0] x);
`ifdef HILAS_SCAN_READBACK_EN
        return x;
`else
        return '0 & x;
`endif
    endfunction

    // Runs one job from a negedge; returns at the negedge of the done cycle
    // (or one cycle after an abort).
    task automatic run_job(input logic [W-1:0] word, input logic clr, input int inject_at,
                           input int abort_at, input int exp_wait, input string tag);
        int           waits;
        int           done_c;
        int           base;
        int           o;
        logic [W-1:0] exp_rd;
        logic         exp_clk;
        exp_rd      = clr ? '0 : rb(exp_chain);
        base        = clr ? R : 0;
        start_valid = 1'b1;
        start_data  = word;
        start_clr   = clr;
        waits       = 0;
        while (start_ready !== 1'b1 && waits < 20) begin
            @(negedge CLK);
            waits++;
        end
        n_checks++;
        if (start_ready !== 1'b1 || (exp_wait >= 0 && waits != exp_wait)) begin
            n_fail++;
            $display("FAIL %s accept_wait: got %0d cycles ready=%b, want %0d", tag, waits, start_ready, exp_wait);
        end
        n_checks++;
        if (rd_data !== exp_prev_rd) begin
            n_fail++;
            $display("FAIL %s rd_hold: got %h want %h", tag, rd_data, exp_prev_rd);
        end
        @(posedge CLK);
        #1;
        start_valid = 1'b0;
        start_data  = W'($urandom);
        start_clr   = 1'($urandom);
        done_c      = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            if (c == abort_at) begin
                RESET_B = 1'b0;
                #1;
                n_checks++;
                if (scan_clk !== 1'b0 || scan_rst_b !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
                    start_ready !== 1'b1 || scan_d !== 1'b0 || rd_data !== '0) begin
                    n_fail++;
                    $display("FAIL %s abort_outputs: got clk=%b rst_b=%b busy=%b done=%b rdy=%b d=%b rd=%h want 0 1 0 0 1 0 00",
                             tag, scan_clk, scan_rst_b, busy, done, start_ready, scan_d, rd_data);
                end
                #1;
                RESET_B = 1'b1;
                @(negedge CLK);
                exp_prev_rd = '0;
                return;
            end
            if (c == inject_at) begin
                start_valid = 1'b1;
                start_data  = W'($urandom);
                start_clr   = 1'b1;
                n_checks++;
                if (start_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_ready: got ready=%b busy=%b want 0 1", tag, start_ready, busy);
                end
            end else if (c == inject_at + 1) begin
                start_valid = 1'b0;
            end
            if (c == 1) begin
                n_checks++;
                if (start_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s cycle1: got ready=%b busy=%b want 0 1", tag, start_ready, busy);
                end
            end
            o = c - 1 - base;
            if (c <= base) begin
                n_checks++;
                if (scan_rst_b !== 1'b0 || scan_clk !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s clr_pins c%0d: got rst_b=%b clk=%b want 0 0", tag, c, scan_rst_b, scan_clk);
                end
            end else if (o < 2 * D * W) begin
                exp_clk = ((o % (2 * D)) >= D);
                n_checks++;
                if (scan_rst_b !== 1'b1 || scan_clk !== exp_clk || scan_d !== word[W-1-o/(2*D)] || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s shift_pins c%0d: got rst_b=%b clk=%b d=%b done=%b want 1 %b %b 0",
                             tag, c, scan_rst_b, scan_clk, scan_d, done, exp_clk, word[W-1-o/(2*D)]);
                end
            end
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
        end
        n_checks++;
        if (done_c != 2 * D * W + 1 + base) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d want %0d", tag, done_c, 2 * D * W + 1 + base);
        end
        n_checks++;
        if (rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rd_data: got %h want %h", tag, rd_data, exp_rd);
        end
        n_checks++;
        if (scan_d !== 1'b0 || scan_clk !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_pins: got d=%b clk=%b busy=%b want 0 0 1", tag, scan_d, scan_clk, busy);
        end
        n_checks++;
        if (chain !== word) begin
            n_fail++;
            $display("FAIL %s chain_word: got %h want %h", tag, chain, word);
        end
        exp_chain   = word;
        exp_prev_rd = exp_rd;
    endtask

    task automatic test_reset();
        RESET_B     = 1'b0;
        start_valid = 1'b0;
        start_data  = '0;
        start_clr   = 1'b0;
        preload_val = 8'h3C;
        #2 preload_stb = 1'b1;
        #1 preload_stb = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (start_ready !== 1'b1 || scan_d !== 1'b0 || scan_clk !== 1'b0 || scan_rst_b !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b d=%b clk=%b rst_b=%b busy=%b done=%b rd=%h want 1 0 0 1 0 0 00",
                     start_ready, scan_d, scan_clk, scan_rst_b, busy, done, rd_data);
        end
        RESET_B = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (chain !== 8'h3C) begin
            n_fail++;
            $display("FAIL reset_chain: got %h want 3c", chain);
        end
        exp_chain   = 8'h3C;
        exp_prev_rd = '0;
    endtask

    task automatic test_basic();
        run_job(8'hA5, 1'b0, -1, -1, 0, "basic");
    endtask

    task automatic test_back_to_back();
        run_job(8'h0F, 1'b0, -1, -1, 1, "b2b");
    endtask

    task automatic test_clear();
        repeat (2) @(negedge CLK);
        run_job(W'($urandom), 1'b1, -1, -1, 0, "clear");
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] w;
        repeat (2) @(negedge CLK);
        w = W'($urandom);
        run_job(w, 1'b0, 10, -1, 0, "ignore");
        repeat (6) @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || start_ready !== 1'b1 || chain !== w) begin
            n_fail++;
            $display("FAIL ignore_after: got busy=%b done=%b rdy=%b chain=%h want 0 0 1 %h", busy, done, start_ready, chain, w);
        end
    endtask

    task automatic test_abort();
        run_job(W'($urandom), 1'b0, -1, 15, 0, "abort");
        repeat (2) @(negedge CLK);
        run_job(8'hFF, 1'b1, -1, -1, 0, "recover");
    endtask

    task automatic test_random();
        int gap;
        for (int j = 0; j < 6; j++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge CLK);
            run_job(W'($urandom), 1'($urandom), -1, -1, (gap == 0) ? 1 : 0, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_clear();
        test_busy_ignore();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
